// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int unsigned STAT_NOT_EMPTY = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_OVERRUN   = 2;
  localparam int unsigned STAT_FRAME_ERR = 3;

  function automatic int unsigned calc_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a pop frees a slot for a same-edge push.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage carries no reset; the empty flag masks stale contents.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with RX FIFO and MMIO data/status registers.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 27_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DATA_ADDR   = 16'hFF10,
  parameter logic [15:0] STATUS_ADDR = 16'hFF11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  input  logic [15:0] mmio_addr,
  input  logic        mmio_read,
  output logic        mmio_hit,
  output logic [7:0]  mmio_rdata,
  output logic        rx_irq
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam int unsigned PW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(DIV - 1);

  rx_state_t        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bit_idx, bit_d;
  logic [7:0]       shreg, shreg_d;
  logic             rx_meta, rx_sync, rx_prev;
  logic             overrun, frame_err;
  logic             push_c, pop_c, ovr_set_c, ferr_set_c, status_rd_c;
  logic             full, empty;
  logic [7:0]       head;
  logic [PW-1:0]    count, count_nx;
  logic [7:0]       status_c;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_c),
    .pop   (pop_c),
    .din   (shreg),
    .full  (full),
    .empty (empty),
    .head  (head),
    .count (count)
  );

  assign pop_c       = mmio_read && (mmio_addr == DATA_ADDR) && !empty;
  assign status_rd_c = mmio_read && (mmio_addr == STATUS_ADDR);
  assign count_nx    = count + PW'(push_c) - PW'(pop_c);

  // Synchroniser, state and sticky flags; a flag set outranks a status-read clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      rx_irq    <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      state     <= state_d;
      cnt       <= cnt_d;
      bit_idx   <= bit_d;
      shreg     <= shreg_d;
      overrun   <= ovr_set_c | (overrun & ~status_rd_c);
      frame_err <= ferr_set_c | (frame_err & ~status_rd_c);
      rx_irq    <= (count_nx != '0);
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt + CNT_W'(1);
    bit_d      = bit_idx;
    shreg_d    = shreg;
    push_c     = 1'b0;
    ovr_set_c  = 1'b0;
    ferr_set_c = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev && !rx_sync) state_d = START;
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_sync, shreg[7:1]};
          bit_d   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_d = '0;
          if (rx_sync) begin
            if (!full || pop_c) push_c = 1'b1;
            else                ovr_set_c = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_set_c = 1'b1;
            state_d    = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_sync) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    status_c                 = '0;
    status_c[STAT_NOT_EMPTY] = ~empty;
    status_c[STAT_FULL]      = full;
    status_c[STAT_OVERRUN]   = overrun;
    status_c[STAT_FRAME_ERR] = frame_err;
  end

  assign mmio_hit = (mmio_addr == DATA_ADDR) || (mmio_addr == STATUS_ADDR);

  always_comb begin
    mmio_rdata = 8'h00;
    if (mmio_addr == DATA_ADDR)        mmio_rdata = empty ? 8'h00 : head;
    else if (mmio_addr == STATUS_ADDR) mmio_rdata = status_c;
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at DIV = 16 (one bit every 16 clocks).
module tb_uart_receiver;
  import uart_pkg::*;

  localparam logic [15:0] DADDR = 16'hFF10;
  localparam logic [15:0] SADDR = 16'hFF11;

  logic        clock;
  logic        reset;
  logic        rx;
  logic [15:0] mmio_addr;
  logic        mmio_read;
  logic        mmio_hit;
  logic [7:0]  mmio_rdata;
  logic        rx_irq;

  int          checks;
  int          errors;
  logic        irq_pre, irq_post;
  logic [7:0]  pop_data;
  logic [7:0]  rd;

  uart_receiver #(
    .CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(8), .DATA_ADDR(DADDR), .STATUS_ADDR(SADDR)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .mmio_addr  (mmio_addr),
    .mmio_read  (mmio_read),
    .mmio_hit   (mmio_hit),
    .mmio_rdata (mmio_rdata),
    .rx_irq     (rx_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  // Stimulus only: drive one frame per negedge; optional pop on cycle pop_cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int stop_len, input int pop_cycle);
    for (int c = 0; c < 144 + stop_len; c++) begin
      @(negedge clock);
      if (c < 16)       rx = 1'b0;
      else if (c < 144) rx = b[3'((c - 16) / 16)];
      else              rx = stop_bit;
      if (c == pop_cycle) begin
        mmio_addr = DADDR;
        mmio_read = 1'b1;
        #1 pop_data = mmio_rdata;
      end else if (c == pop_cycle + 1) begin
        mmio_read = 1'b0;
        mmio_addr = 16'h0000;
      end
      if (c == 154) irq_pre = rx_irq;
      if (c == 155) irq_post = rx_irq;
    end
  endtask

  // Stimulus only: one-cycle read strobe, returns the combinational read data.
  task automatic mmio_rd(input logic [15:0] addr, output logic [7:0] data);
    @(negedge clock);
    mmio_addr = addr;
    mmio_read = 1'b1;
    #1 data = mmio_rdata;
    @(negedge clock);
    mmio_read = 1'b0;
    mmio_addr = 16'h0000;
  endtask

  task automatic test_reset;
    mmio_addr = DADDR;
    #1;
    checks++; if (mmio_rdata !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", mmio_rdata); end
    checks++; if (mmio_hit !== 1'b1) begin errors++; $display("FAIL reset_hit_data got %b exp 1", mmio_hit); end
    mmio_addr = SADDR;
    #1;
    checks++; if (mmio_rdata !== 8'h00) begin errors++; $display("FAIL reset_status got %h exp 00", mmio_rdata); end
    mmio_addr = 16'hFF12;
    #1;
    checks++; if (mmio_hit !== 1'b0) begin errors++; $display("FAIL miss_hit got %b exp 0", mmio_hit); end
    checks++; if (mmio_rdata !== 8'h00) begin errors++; $display("FAIL miss_rdata got %h exp 00", mmio_rdata); end
    mmio_addr = 16'h0000;
    checks++; if (rx_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", rx_irq); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp IDLE", dut.state); end
  endtask

  task automatic test_single_frame;
    send_frame(8'hA5, 1'b1, 16, -10);
    checks++; if (irq_pre !== 1'b0) begin errors++; $display("FAIL irq_before_stop got %b exp 0", irq_pre); end
    checks++; if (irq_post !== 1'b1) begin errors++; $display("FAIL irq_after_stop got %b exp 1", irq_post); end
    idle(4);
    mmio_rd(SADDR, rd);
    checks++; if (rd !== 8'h01) begin errors++; $display("FAIL single_status got %h exp 01", rd); end
    mmio_rd(DADDR, rd);
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", rd); end
    checks++; if (rx_irq !== 1'b0) begin errors++; $display("FAIL single_irq_drop got %b exp 0", rx_irq); end
    mmio_rd(DADDR, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL single_empty_data got %h exp 00", rd); end
  endtask

  task automatic test_glitch;
    @(negedge clock); rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(30);
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL glitch_state got %0d exp IDLE", dut.state); end
    checks++; if (rx_irq !== 1'b0) begin errors++; $display("FAIL glitch_irq got %b exp 0", rx_irq); end
    mmio_rd(SADDR, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL glitch_status got %h exp 00", rd); end
  endtask

  task automatic test_frame_error;
    send_frame(8'h3C, 1'b0, 40, -10);
    checks++; if (dut.state !== BREAK) begin errors++; $display("FAIL ferr_in_break got %0d exp BREAK", dut.state); end
    mmio_rd(SADDR, rd);
    checks++; if (rd !== 8'h08) begin errors++; $display("FAIL ferr_status got %h exp 08", rd); end
    mmio_rd(SADDR, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL ferr_status_clear got %h exp 00", rd); end
    checks++; if (dut.state !== BREAK) begin errors++; $display("FAIL ferr_hold_break got %0d exp BREAK", dut.state); end
    @(negedge clock); rx = 1'b1;
    idle(5);
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL ferr_leave_break got %0d exp IDLE", dut.state); end
    send_frame(8'h5A, 1'b1, 16, -10);
    idle(4);
    mmio_rd(DADDR, rd);
    checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL ferr_next_frame got %h exp 5a", rd); end
  endtask

  task automatic test_overrun;
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 16, -10);
    idle(4);
    mmio_rd(SADDR, rd);
    checks++; if (rd !== 8'h07) begin errors++; $display("FAIL ovr_status got %h exp 07", rd); end
    for (int i = 0; i < 8; i++) begin
      mmio_rd(DADDR, rd);
      checks++; if (rd !== 8'(i)) begin errors++; $display("FAIL ovr_data%0d got %h exp %h", i, rd, 8'(i)); end
    end
    mmio_rd(SADDR, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL ovr_status_after got %h exp 00", rd); end
  endtask

  task automatic test_full_pop;
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1, 16, -10);
    idle(4);
    mmio_rd(SADDR, rd);
    checks++; if (rd !== 8'h03) begin errors++; $display("FAIL full_status got %h exp 03", rd); end
    send_frame(8'h77, 1'b1, 16, 154);
    checks++; if (pop_data !== 8'h10) begin errors++; $display("FAIL full_pop_data got %h exp 10", pop_data); end
    idle(4);
    mmio_rd(SADDR, rd);
    checks++; if (rd !== 8'h03) begin errors++; $display("FAIL full_pop_status got %h exp 03", rd); end
    for (int i = 1; i < 8; i++) begin
      mmio_rd(DADDR, rd);
      checks++; if (rd !== 8'h10 + 8'(i)) begin errors++; $display("FAIL full_data%0d got %h exp %h", i, rd, 8'h10 + 8'(i)); end
    end
    mmio_rd(DADDR, rd);
    checks++; if (rd !== 8'h77) begin errors++; $display("FAIL full_last got %h exp 77", rd); end
    mmio_rd(SADDR, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL full_final_status got %h exp 00", rd); end
  endtask

  task automatic test_reset_mid_frame;
    @(negedge clock); rx = 1'b0;
    idle(16);
    rx = 1'b1;
    idle(40);
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(200);
    checks++; if (rx_irq !== 1'b0) begin errors++; $display("FAIL rst_mid_irq got %b exp 0", rx_irq); end
    mmio_rd(SADDR, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_mid_status got %h exp 00", rd); end
    mmio_rd(DADDR, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL rst_mid_data got %h exp 00", rd); end
    send_frame(8'h12, 1'b1, 16, -10);
    idle(4);
    mmio_rd(DADDR, rd);
    checks++; if (rd !== 8'h12) begin errors++; $display("FAIL rst_mid_next got %h exp 12", rd); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    irq_pre   = 1'bx;
    irq_post  = 1'bx;
    pop_data  = 8'hxx;
    reset     = 1'b0;
    rx        = 1'b1;
    mmio_addr = 16'h0000;
    mmio_read = 1'b0;
    idle(3);
    test_reset;
    reset = 1'b1;
    idle(3);
    test_single_frame;
    test_glitch;
    test_frame_error;
    test_overrun;
    test_full_pop;
    test_reset_mid_frame;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Memory-mapped UART receiver that consumes the board's `uart_rx` pin and supplies received bytes to the CPU core through the data-memory MMIO path. It is the input-side counterpart of the existing TX-only UART. It deserialises 8N1 frames, buffers bytes in a small FIFO, and returns FIFO data and status on core reads. The top level muxes `mmio_rdata` into the core's data-in path whenever `mmio_hit` is high.

## Interface
- `CLK_FREQ`, 27_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate in baud.
- `FIFO_DEPTH`, 8: receive FIFO entries. Must be a power of two, ≥ 2.
- `DATA_ADDR`, 16'hFF10: MMIO address of the RX data register. Reads pop the FIFO.
- `STATUS_ADDR`, 16'hFF11: MMIO address of the RX status register.
- `clock`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `rx`, in, 1: serial line. Asynchronous to `clock`; idles high.
- `mmio_addr`, in, 16: core data address.
- `mmio_read`, in, 1: one-cycle read strobe from the core.
- `mmio_hit`, out, 1: high when `mmio_addr` equals `DATA_ADDR` or `STATUS_ADDR`. Combinational.
- `mmio_rdata`, out, 8: read data. Combinational from `mmio_addr` and current state.
- `rx_irq`, out, 1: registered; high while the FIFO is not empty.

## Operation
- `DIV = CLK_FREQ / BAUD`, truncated (234 at the defaults). The bit counter is `$clog2(DIV)` bits wide.
- `rx` passes through a 2-flop synchroniser. The synchroniser flops reset to 1.
- FSM states:
  - IDLE: on a synchronised falling edge, clear the counter and go to START.
  - START: after `DIV/2` cycles, sample the line. If low, go to DATA. If high (glitch), return to IDLE.
  - DATA: take 8 samples, one every `DIV` cycles, LSB first, shifting into the shift register. Go to STOP after the 8th sample.
  - STOP: after `DIV` cycles, sample the line.
    - High with FIFO not full: push the byte; go to IDLE.
    - High with FIFO full: drop the byte, set `overrun`; go to IDLE.
    - Low: drop the byte, set `frame_err`; go to BREAK.
  - BREAK: wait until the synchronised line is high, then go to IDLE.
- Status byte: bit0 = not empty, bit1 = full, bit2 = `overrun` (sticky), bit3 = `frame_err` (sticky), bits 7:4 = 0.
- Read of `DATA_ADDR`: `mmio_rdata` = FIFO head. If the FIFO is empty, `mmio_rdata` = 8'h00 and nothing is popped.
- `mmio_read` with `DATA_ADDR` and FIFO not empty: pop at the next clock edge.
- `mmio_read` with `STATUS_ADDR`: the current value is returned. `overrun` and `frame_err` clear at that edge.
- Any other address: `mmio_hit` = 0 and `mmio_rdata` = 8'h00.

## Timing
- Reset values: FSM in IDLE; FIFO empty; `overrun` = 0, `frame_err` = 0; `rx_irq` = 0; `mmio_rdata` = 8'h00; `mmio_hit` follows the address only.
- Reset mid-frame aborts the frame. No partial byte is pushed.
- Line-to-sample latency is 2 cycles (synchroniser).
- The pushed byte is visible on `DATA_ADDR` reads on the cycle after the STOP sample. `rx_irq` rises on that same cycle.
- Push and pop on the same edge:
  - FIFO not empty: both take effect; the count is unchanged.
  - FIFO full: the pop frees the slot, the push is accepted, and there is no overrun.
- A sticky-flag set and a status-read clear on the same edge: the set wins.
- Pointers are `$clog2(FIFO_DEPTH)+1` bits wide and wrap naturally. Full and empty are derived from the MSB compare.

## Structure
- Package `uart_pkg`:
  - `rx_state_t` enum (IDLE, START, DATA, STOP, BREAK).
  - Status bit index constants.
  - A `calc_div(CLK_FREQ, BAUD)` function.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/head). The FIFO is reusable by a later buffered TX.
- The FSM, synchroniser and MMIO decode stay in `uart_receiver`.

## Test plan
All cases use `CLK_FREQ` = 16 and `BAUD` = 1, giving `DIV` = 16.
- Single frame: send 8'hA5 -> `rx_irq` rises. Status read returns 8'h01. Data read returns 8'hA5, then `rx_irq` drops. A further data read returns 8'h00.
- Glitch: pull `rx` low for 4 cycles only -> FSM returns to IDLE; no push; status stays 8'h00.
- Framing error: send 8'h3C with a low stop bit held for 40 cycles -> no push; status returns 8'h08; the next status read returns 8'h00; FSM leaves BREAK only after `rx` goes high.
- Overrun: send 9 bytes 8'h00..8'h08 with no reads -> status returns 8'h07. Data reads return 8'h00..8'h07 in order.
- Full with simultaneous pop: fill 8 entries, then pop on the exact STOP-sample edge of a 9th byte 8'h77 -> no overrun; the last entry read is 8'h77.
- Reset asserted mid-DATA of byte 8'hFF -> after release, FIFO is empty, status reads 8'h00, and the next clean frame 8'h12 is received correctly.
